// File: rtl/riscv_pkg.sv
// Shared types for the hazard unit: operand-forward selects, FSM states, MDU latency.
package riscv_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        HZ_IDLE,
        HZ_MDU_BUSY
    } hz_state_e;

    localparam int MDU_LAT_DEF = 34;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-unit bundle: pipeline register/source info in, stall/flush/forward controls out.
interface hazard_ctrl_unit_if #(
    parameter int REGW = 5
);
    logic [REGW-1:0] rs1_d;
    logic [REGW-1:0] rs2_d;
    logic [REGW-1:0] rs1_e;
    logic [REGW-1:0] rs2_e;
    logic [REGW-1:0] rd_e;
    logic [REGW-1:0] rd_m;
    logic [REGW-1:0] rd_w;
    logic            reg_write_m;
    logic            reg_write_w;
    logic            load_e;
    logic            mdu_start_e;
    logic            br_taken_e;
    logic            kill_i;
    logic [1:0]      forward_a;
    logic [1:0]      forward_b;
    logic            stall_f;
    logic            stall_d;
    logic            stall_e;
    logic            flush_d;
    logic            flush_e;
    logic            flush_m;
    logic            mdu_busy;
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_flush_cnt;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e,
        output rd_e, rd_m, rd_w,
        output reg_write_m, reg_write_w,
        output load_e, mdu_start_e, br_taken_e, kill_i,
        input  forward_a, forward_b,
        input  stall_f, stall_d, stall_e,
        input  flush_d, flush_e, flush_m,
        input  mdu_busy, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e,
        input  rd_e, rd_m, rd_w,
        input  reg_write_m, reg_write_w,
        input  load_e, mdu_start_e, br_taken_e, kill_i,
        output forward_a, forward_b,
        output stall_f, stall_d, stall_e,
        output flush_d, flush_e, flush_m,
        output mdu_busy, perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/fwd_select.sv
// Operand-forward select for one E-stage source register; M beats W, x0 never forwards.
module fwd_select
    import riscv_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] rs,
    input  logic [REGW-1:0] rd_m,
    input  logic [REGW-1:0] rd_w,
    input  logic            reg_write_m,
    input  logic            reg_write_w,
    output fwd_sel_e        sel
);

    logic nz;
    logic hit_m;
    logic hit_w;

    assign nz    = rs != '0;
    assign hit_m = nz && reg_write_m && (rs == rd_m);
    assign hit_w = nz && reg_write_w && (rs == rd_w);

    always_comb begin
        sel = FWD_RF;
        if (hit_m) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// 5-stage hazard control: forwarding, load-use bubbles, MDU hold FSM, branch/kill flushes.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_ctrl_unit
    import riscv_pkg::*;
#(
    parameter int REGW    = 5,
    parameter int MDU_LAT = MDU_LAT_DEF,
    parameter int CNTW    = $clog2(MDU_LAT)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hazard_ctrl_unit_if.slave hz
);

    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(MDU_LAT - 2);

    hz_state_e       state;
    hz_state_e       state_nx;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nx;

    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;
    logic     load_use;
    logic     mdu_go;
    logic     stall_f;
    logic     stall_d;
    logic     stall_e;
    logic     flush_d;
    logic     flush_e;
    logic     flush_m;

    fwd_select #(.REGW(REGW)) u_fwd_a (
        .rs          (hz.rs1_e),
        .rd_m        (hz.rd_m),
        .rd_w        (hz.rd_w),
        .reg_write_m (hz.reg_write_m),
        .reg_write_w (hz.reg_write_w),
        .sel         (fwd_a)
    );

    fwd_select #(.REGW(REGW)) u_fwd_b (
        .rs          (hz.rs2_e),
        .rd_m        (hz.rd_m),
        .rd_w        (hz.rd_w),
        .reg_write_m (hz.reg_write_m),
        .reg_write_w (hz.reg_write_w),
        .sel         (fwd_b)
    );

    assign load_use = hz.load_e && (hz.rd_e != '0) &&
                      ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
    assign mdu_go   = hz.mdu_start_e && !hz.kill_i && !hz.br_taken_e;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= HZ_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        if (hz.kill_i) begin
            state_nx = HZ_IDLE;
            cnt_nx   = '0;
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            flush_m  = 1'b1;
        end else if (state == HZ_MDU_BUSY) begin
            // E holds the MDU op; a stray branch here is ignored until IDLE
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            if (cnt == '0) begin
                state_nx = HZ_IDLE;
            end else begin
                cnt_nx = cnt - 1'b1;
            end
        end else if (hz.br_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (mdu_go) begin
            state_nx = HZ_MDU_BUSY;
            cnt_nx   = CNT_INIT;
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            flush_m  = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
        if (rst_i) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            stall_e = 1'b0;
            flush_d = 1'b0;
            flush_e = 1'b0;
            flush_m = 1'b0;
        end
    end

    assign hz.forward_a = rst_i ? 2'b00 : fwd_a;
    assign hz.forward_b = rst_i ? 2'b00 : fwd_b;
    assign hz.stall_f   = stall_f;
    assign hz.stall_d   = stall_d;
    assign hz.stall_e   = stall_e;
    assign hz.flush_d   = flush_d;
    assign hz.flush_e   = flush_e;
    assign hz.flush_m   = flush_m;
    assign hz.mdu_busy  = (state == HZ_MDU_BUSY) && !rst_i;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_f) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush_d || flush_e || flush_m) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign hz.perf_stall_cnt = perf_stall_q;
    assign hz.perf_flush_cnt = perf_flush_q;
`else
    assign hz.perf_stall_cnt = 32'd0;
    assign hz.perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with MDU_LAT=4.
module tb_hazard_ctrl_unit;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   failures = 0;

    hazard_ctrl_unit_if #(.REGW(5)) hz ();

    hazard_ctrl_unit #(
        .REGW    (5),
        .MDU_LAT (4)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (hz.slave)
    );

    always #5 clk_i = ~clk_i;

    // {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy}
    logic [6:0] ctl;
    assign ctl = {hz.stall_f, hz.stall_d, hz.stall_e,
                  hz.flush_d, hz.flush_e, hz.flush_m, hz.mdu_busy};

    task automatic clear_inputs();
        hz.rs1_d       = '0;
        hz.rs2_d       = '0;
        hz.rs1_e       = '0;
        hz.rs2_e       = '0;
        hz.rd_e        = '0;
        hz.rd_m        = '0;
        hz.rd_w        = '0;
        hz.reg_write_m = 1'b0;
        hz.reg_write_w = 1'b0;
        hz.load_e      = 1'b0;
        hz.mdu_start_e = 1'b0;
        hz.br_taken_e  = 1'b0;
        hz.kill_i      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1;
        hz.load_e = 1'b1;
        hz.rd_e   = 5'd7;
        hz.rs1_d  = 5'd7;
        hz.rs1_e  = 5'd3;
        hz.rd_m   = 5'd3;
        hz.reg_write_m = 1'b1;
        step();
        step();
        #1;
        checks++;
        if (ctl !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0);
        end
        checks++;
        if (hz.forward_a !== 2'b00) begin
            failures++;
            $display("FAIL reset_fwd_a got=%b exp=00", hz.forward_a);
        end
        checks++;
        if (hz.perf_stall_cnt !== 32'd0 || hz.perf_flush_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_perf got=%0d/%0d exp=0/0",
                     hz.perf_stall_cnt, hz.perf_flush_cnt);
        end
        clear_inputs();
        rst_i = 1'b0;
        step();
        #1;
        checks++;
        if (ctl !== 7'b0) begin
            failures++;
            $display("FAIL post_reset_ctl got=%b exp=%b", ctl, 7'b0);
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        hz.rs1_e = 5'd5;
        hz.rs2_e = 5'd5;
        hz.rd_m  = 5'd5;
        hz.rd_w  = 5'd5;
        hz.reg_write_m = 1'b1;
        hz.reg_write_w = 1'b1;
        #1;
        checks++;
        if ({hz.forward_a, hz.forward_b} !== 4'b0101) begin
            failures++;
            $display("FAIL fwd_m_both got=%b exp=0101", {hz.forward_a, hz.forward_b});
        end
        hz.reg_write_m = 1'b0;
        #1;
        checks++;
        if ({hz.forward_a, hz.forward_b} !== 4'b1010) begin
            failures++;
            $display("FAIL fwd_w_both got=%b exp=1010", {hz.forward_a, hz.forward_b});
        end
        hz.rs1_e = 5'd3;
        hz.rs2_e = 5'd4;
        hz.rd_m  = 5'd3;
        hz.rd_w  = 5'd4;
        hz.reg_write_m = 1'b1;
        #1;
        checks++;
        if ({hz.forward_a, hz.forward_b} !== 4'b0110) begin
            failures++;
            $display("FAIL fwd_mixed got=%b exp=0110", {hz.forward_a, hz.forward_b});
        end
        hz.rs1_e = 5'd9;
        hz.rs2_e = 5'd31;
        #1;
        checks++;
        if ({hz.forward_a, hz.forward_b} !== 4'b0000) begin
            failures++;
            $display("FAIL fwd_none got=%b exp=0000", {hz.forward_a, hz.forward_b});
        end
        checks++;
        if (ctl !== 7'b0) begin
            failures++;
            $display("FAIL fwd_no_ctl got=%b exp=%b", ctl, 7'b0);
        end
    endtask

    task automatic test_x0();
        clear_inputs();
        hz.rs1_e = 5'd0;
        hz.rd_m  = 5'd0;
        hz.rd_w  = 5'd0;
        hz.reg_write_m = 1'b1;
        hz.reg_write_w = 1'b1;
        #1;
        checks++;
        if (hz.forward_a !== 2'b00) begin
            failures++;
            $display("FAIL x0_fwd got=%b exp=00", hz.forward_a);
        end
        hz.load_e = 1'b1;
        hz.rd_e   = 5'd0;
        hz.rs1_d  = 5'd0;
        hz.rs2_d  = 5'd0;
        #1;
        checks++;
        if (ctl !== 7'b0) begin
            failures++;
            $display("FAIL x0_load_use got=%b exp=%b", ctl, 7'b0);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        step();
        hz.load_e = 1'b1;
        hz.rd_e   = 5'd7;
        hz.rs1_d  = 5'd2;
        hz.rs2_d  = 5'd7;
        #1;
        checks++;
        if (ctl !== 7'b1100100) begin
            failures++;
            $display("FAIL load_use got=%b exp=%b", ctl, 7'b1100100);
        end
        step();
        hz.load_e = 1'b0;
        hz.rd_e   = 5'd0;
        hz.rs2_e  = 5'd7;
        hz.rd_m   = 5'd7;
        hz.reg_write_m = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'b0 || hz.forward_b !== 2'b01) begin
            failures++;
            $display("FAIL load_use_after got=%b/%b exp=%b/01",
                     ctl, hz.forward_b, 7'b0);
        end
        step();
        clear_inputs();
        hz.load_e = 1'b1;
        hz.rd_e   = 5'd7;
        hz.rs2_d  = 5'd7;
        hz.br_taken_e = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'b0001100) begin
            failures++;
            $display("FAIL branch_over_lu got=%b exp=%b", ctl, 7'b0001100);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_mdu();
        logic [6:0] exp_ctl [6];
        exp_ctl[0] = 7'b1110010;
        exp_ctl[1] = 7'b1110011;
        exp_ctl[2] = 7'b1110011;
        exp_ctl[3] = 7'b1110011;
        exp_ctl[4] = 7'b0000000;
        exp_ctl[5] = 7'b0000000;
        clear_inputs();
        step();
        hz.mdu_start_e = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (ctl !== exp_ctl[i]) begin
                failures++;
                $display("FAIL mdu_cycle%0d got=%b exp=%b", i + 1, ctl, exp_ctl[i]);
            end
            step();
            hz.mdu_start_e = 1'b0;
        end
    endtask

    task automatic test_branch_in_busy();
        clear_inputs();
        step();
        hz.mdu_start_e = 1'b1;
        step();
        hz.mdu_start_e = 1'b0;
        hz.br_taken_e  = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'b1110011) begin
            failures++;
            $display("FAIL br_in_busy got=%b exp=%b", ctl, 7'b1110011);
        end
        hz.br_taken_e = 1'b0;
        repeat (4) step();
        #1;
        checks++;
        if (ctl !== 7'b0) begin
            failures++;
            $display("FAIL br_in_busy_done got=%b exp=%b", ctl, 7'b0);
        end
    endtask

    task automatic test_kill();
        clear_inputs();
        step();
        hz.mdu_start_e = 1'b1;
        step();
        hz.mdu_start_e = 1'b0;
        step();
        hz.kill_i = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'b0001111) begin
            failures++;
            $display("FAIL kill_cycle got=%b exp=%b", ctl, 7'b0001111);
        end
        step();
        hz.kill_i = 1'b0;
        #1;
        checks++;
        if (ctl !== 7'b0) begin
            failures++;
            $display("FAIL kill_after got=%b exp=%b", ctl, 7'b0);
        end
        step();
        hz.load_e = 1'b1;
        hz.rd_e   = 5'd4;
        hz.rs1_d  = 5'd4;
        hz.kill_i = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'b0001110) begin
            failures++;
            $display("FAIL kill_over_lu got=%b exp=%b", ctl, 7'b0001110);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_perf();
        logic [31:0] exp_s;
        logic [31:0] exp_f;
`ifdef HAZARD_PERF_EN
        exp_s = 32'd5;
        exp_f = 32'd5;
`else
        exp_s = 32'd0;
        exp_f = 32'd0;
`endif
        clear_inputs();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        hz.mdu_start_e = 1'b1;
        step();
        hz.mdu_start_e = 1'b0;
        repeat (3) step();
        hz.load_e = 1'b1;
        hz.rd_e   = 5'd7;
        hz.rs1_d  = 5'd7;
        step();
        clear_inputs();
        step();
        checks++;
        if (hz.perf_stall_cnt !== exp_s) begin
            failures++;
            $display("FAIL perf_stall got=%0d exp=%0d", hz.perf_stall_cnt, exp_s);
        end
        checks++;
        if (hz.perf_flush_cnt !== exp_f) begin
            failures++;
            $display("FAIL perf_flush got=%0d exp=%0d", hz.perf_flush_cnt, exp_f);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        checks++;
        if (hz.perf_stall_cnt !== 32'd0 || hz.perf_flush_cnt !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset got=%0d/%0d exp=0/0",
                     hz.perf_stall_cnt, hz.perf_flush_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_x0();
        test_load_use();
        test_mdu();
        test_branch_in_busy();
        test_kill();
        test_perf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
